inference_sequencer: RTL and testbench

- Controls one inference pass by driving the request side of sram_buffer: get_weights, get_inputs, get_out.
- Loads NUM_WEIGHTS weight rows into the systolic array, then streams num_inputs input vectors into it.
- Waits for pipeline drain, then commands output collection.
- Reports busy, done and a sticky error to the AHB slave's status register.

---
 rtl/inference_sequencer.sv | 161 ++++++++++++++++
 tb/tb_inference_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inference_sequencer.sv
// Inference pass sequencer: fetches weight rows and input vectors from the
// buffer, feeds them to the systolic array, waits for the pipeline to drain,
// then commands output collection and reports busy/done/err.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no pass in progress, waiting for start
// REQ_W   | get_weights held until the buffer returns a word
// LOAD_W  | captured weight row offered to the array
// WAIT_W  | wait for data_ready to fall before the next request
// REQ_I   | get_inputs held until the buffer returns a word
// LOAD_I  | captured input vector offered to the array
// WAIT_I  | wait for data_ready to fall before the next request
// DRAIN   | idle cycles to let the array pipeline empty
// REQ_OUT | get_out held until the buffer finishes collection
// ERR     | one-cycle error exit: err set, done pulsed
module inference_sequencer #(
  parameter int NUM_WEIGHTS  = 8,
  parameter int DRAIN_CYCLES = 16,
  parameter int TIMEOUT      = 1023
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [7:0]  num_inputs,
  input  logic        data_ready,
  input  logic [63:0] data,
  input  logic        out_done,
  input  logic        occupancy_err,
  input  logic        array_ready,
  output logic        get_weights,
  output logic        get_inputs,
  output logic        get_out,
  output logic        weight_load,
  output logic [2:0]  weight_row,
  output logic        input_load,
  output logic [63:0] array_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [3:0] {
    IDLE, REQ_W, LOAD_W, WAIT_W, REQ_I, LOAD_I, WAIT_I, DRAIN, REQ_OUT, ERR
  } state_t;

  localparam logic [2:0] W_LAST = 3'(NUM_WEIGHTS - 1);
  // DRAIN_CYCLES of 0 and 1 both spend a single cycle in DRAIN.
  localparam logic [7:0] D_LAST = (DRAIN_CYCLES == 0) ? 8'd0 : 8'(DRAIN_CYCLES - 1);
  localparam logic [9:0] T_MAX  = 10'(TIMEOUT);

  state_t      state, nxt;
  logic [2:0]  wcnt;
  logic [7:0]  icnt;
  logic [7:0]  dcnt;
  logic [7:0]  n_in;
  logic [9:0]  tcnt;
  logic [63:0] data_q;
  logic        w_all;
  logic        err_q;
  logic        done_q;

  // Next-state decode and request/load strobes; occupancy_err overrides all.
  always_comb begin
    nxt         = state;
    get_weights = 1'b0;
    get_inputs  = 1'b0;
    get_out     = 1'b0;
    weight_load = 1'b0;
    input_load  = 1'b0;
    case (state)
      IDLE:    if (start) nxt = (num_inputs == 8'd0) ? ERR : REQ_W;
      REQ_W: begin
        get_weights = 1'b1;
        if (data_ready)         nxt = LOAD_W;
        else if (tcnt == T_MAX) nxt = ERR;
      end
      LOAD_W: begin
        weight_load = array_ready;
        if (array_ready) nxt = WAIT_W;
      end
      WAIT_W: begin
        if (!data_ready)        nxt = w_all ? REQ_I : REQ_W;
        else if (tcnt == T_MAX) nxt = ERR;
      end
      REQ_I: begin
        get_inputs = 1'b1;
        if (data_ready)         nxt = LOAD_I;
        else if (tcnt == T_MAX) nxt = ERR;
      end
      LOAD_I: begin
        input_load = array_ready;
        if (array_ready) nxt = WAIT_I;
      end
      WAIT_I: begin
        if (!data_ready)        nxt = (icnt == n_in) ? DRAIN : REQ_I;
        else if (tcnt == T_MAX) nxt = ERR;
      end
      DRAIN:   if (dcnt == D_LAST) nxt = REQ_OUT;
      REQ_OUT: begin
        get_out = 1'b1;
        if (out_done) nxt = IDLE;
      end
      ERR:     nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // ERR already exits in one cycle, so a buffer error there is not re-entered.
    if (occupancy_err && state != IDLE && state != ERR) begin
      nxt         = ERR;
      weight_load = 1'b0;
      input_load  = 1'b0;
    end
  end

  // State register, counters, captured word and status flags.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state  <= IDLE;
      wcnt   <= '0;
      icnt   <= '0;
      dcnt   <= '0;
      n_in   <= '0;
      tcnt   <= '0;
      data_q <= '0;
      w_all  <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state <= nxt;
      tcnt  <= (nxt != state) ? 10'd0 : tcnt + 10'd1;
      dcnt  <= (state == DRAIN) ? dcnt + 8'd1 : 8'd0;

      if (state == IDLE && start) begin
        n_in  <= num_inputs;
        wcnt  <= '0;
        icnt  <= '0;
        w_all <= 1'b0;
      end

      if ((state == REQ_W || state == REQ_I) && data_ready) data_q <= data;

      if (weight_load) begin
        wcnt  <= wcnt + 3'd1;
        w_all <= (wcnt == W_LAST);
      end
      if (input_load) icnt <= icnt + 8'd1;

      if (nxt == ERR)                     err_q <= 1'b1;
      else if (state == IDLE && start)    err_q <= 1'b0;

      done_q <= (nxt == ERR) || (state == REQ_OUT && nxt == IDLE);
    end
  end

  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign err        = err_q;
  assign array_data = (state == LOAD_W || state == LOAD_I) ? data_q : 64'd0;
  assign weight_row = (state == LOAD_W) ? wcnt : 3'd0;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: buffer/array responders plus a
// negedge monitor that tallies loads, requests and protocol violations.
module tb_inference_sequencer;

  localparam int NW = 8;
  localparam int DC = 16;
  localparam int TO = 1023;
  localparam logic [63:0] DBASE = 64'h5A00_0000_0000_0100;
  localparam logic [63:0] JUNK  = 64'hDEAD_BEEF_0BAD_F00D;

  logic        clk = 1'b0;
  logic        n_rst, start, data_ready, out_done, occupancy_err, array_ready;
  logic [7:0]  num_inputs;
  logic [63:0] data;
  logic        get_weights, get_inputs, get_out, weight_load, input_load;
  logic [2:0]  weight_row;
  logic [63:0] array_data;
  logic        busy, done, err;

  inference_sequencer #(.NUM_WEIGHTS(NW), .DRAIN_CYCLES(DC), .TIMEOUT(TO)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .num_inputs(num_inputs),
    .data_ready(data_ready), .data(data), .out_done(out_done),
    .occupancy_err(occupancy_err), .array_ready(array_ready),
    .get_weights(get_weights), .get_inputs(get_inputs), .get_out(get_out),
    .weight_load(weight_load), .weight_row(weight_row), .input_load(input_load),
    .array_data(array_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // monitor tallies
  int wl_cnt, il_cnt, gw_rise, gi_rise, gw_hi, gout_len, gout_first, il_last;
  int done_cnt, done_cyc, row_err, dat_err, viol, stall_cyc;
  logic busy_at_done, err_at_done;
  logic gw_d = 1'b0, gi_d = 1'b0;

  task automatic mon_clr();
    wl_cnt = 0; il_cnt = 0; gw_rise = 0; gi_rise = 0; gw_hi = 0; gout_len = 0;
    gout_first = 0; il_last = 0; done_cnt = 0; done_cyc = 0; row_err = 0;
    dat_err = 0; viol = 0; stall_cyc = 0; busy_at_done = 1'b0; err_at_done = 1'b0;
  endtask

  // Sample just before the edge the DUT acts on; inputs change only after posedges.
  always @(negedge clk) begin : mon
    logic [63:0] exp_w;
    exp_w = (wl_cnt < NW) ? DBASE + 64'(wl_cnt) : DBASE + 64'(NW + il_cnt);
    if (get_weights && !gw_d) gw_rise++;
    if (get_inputs && !gi_d) gi_rise++;
    gw_d = get_weights;
    gi_d = get_inputs;
    if (get_weights) gw_hi++;
    if (get_out) begin
      if (gout_len == 0) gout_first = cyc;
      gout_len++;
    end
    if (weight_load) begin
      if (weight_row !== 3'(wl_cnt)) row_err++;
      if (array_data !== exp_w) dat_err++;
      wl_cnt++;
    end
    if (input_load) begin
      if (array_data !== exp_w) dat_err++;
      il_cnt++;
      il_last = cyc;
    end
    if (array_data != 64'd0 && !array_ready) begin
      stall_cyc++;
      if (array_data !== exp_w) dat_err++;
      if (get_weights || get_inputs) viol++;
    end
    if (int'(get_weights) + int'(get_inputs) + int'(get_out) > 1) viol++;
    if (weight_load && input_load) viol++;
    if ((weight_load || input_load) && (!array_ready || occupancy_err)) viol++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = busy;
      err_at_done = err;
    end
  end

  // buffer read side
  int rsp_dly = 4, rsp_hold = 1, rsp_idx = 0;
  bit rsp_en = 1'b1;

  initial begin : responder
    data_ready = 1'b0;
    data = JUNK;
    forever begin
      @(posedge clk); #1;
      if (rsp_en && (get_weights || get_inputs)) begin
        repeat (rsp_dly) begin @(posedge clk); #1; end
        data_ready = 1'b1;
        data = DBASE + 64'(rsp_idx);
        rsp_idx++;
        repeat (rsp_hold) begin @(posedge clk); #1; end
        data_ready = 1'b0;
        data = JUNK;
      end
    end
  end

  // output collection side: out_done three cycles after get_out is seen
  initial begin : collector
    out_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (get_out) begin
        repeat (3) begin @(posedge clk); #1; end
        out_done = 1'b1;
        @(posedge clk); #1;
        out_done = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_start(input logic [7:0] n);
    num_inputs = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int base;
    base = done_cnt;
    for (int i = 0; i < budget && done_cnt == base; i++) tick();
    chk({tag, "_done_seen"}, 64'(done_cnt != base), 64'd1);
  endtask

  initial begin : main
    int s;
    n_rst = 1'b1; start = 1'b0; num_inputs = 8'd0; occupancy_err = 1'b0; array_ready = 1'b1;
    mon_clr();
    idle(2);
    n_rst = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {busy, done, err, get_weights, get_inputs, get_out, weight_load, input_load}, 8'h00);
    chk("rst_data", array_data, 64'd0);
    chk("rst_row", weight_row, 3'd0);

    // normal pass, 3 inputs
    idle(2); mon_clr(); rsp_idx = 0; rsp_dly = 4; rsp_hold = 1;
    do_start(8'd3);
    @(negedge clk);
    chk("n_busy", busy, 1'b1);
    wait_done("n", 400);
    chk("n_busy_at_done", busy_at_done, 1'b0);
    chk("n_err_at_done", err_at_done, 1'b0);
    chk("n_wloads", wl_cnt, 8);
    chk("n_iloads", il_cnt, 3);
    chk("n_gw_rise", gw_rise, 8);
    chk("n_gi_rise", gi_rise, 3);
    chk("n_row_order", row_err, 0);
    chk("n_data", dat_err, 0);
    chk("n_drain_gap", gout_first - il_last, DC + 2);
    chk("n_gout_len", gout_len, 4);
    idle(3);
    chk("n_done_once", done_cnt, 1);
    chk("n_viol", viol, 0);

    // backpressure on weight row 2
    idle(5); mon_clr(); rsp_idx = 0;
    do_start(8'd1);
    for (int i = 0; i < 200 && wl_cnt < 2; i++) tick();
    array_ready = 1'b0;
    for (int i = 0; i < 200 && stall_cyc < 5; i++) tick();
    array_ready = 1'b1;
    wait_done("bp", 400);
    chk("bp_stall", stall_cyc, 5);
    chk("bp_wloads", wl_cnt, 8);
    chk("bp_gw_rise", gw_rise, 8);
    chk("bp_row_order", row_err, 0);
    chk("bp_data", dat_err, 0);
    chk("bp_viol", viol, 0);

    // long data_ready, plus start while busy
    idle(5); mon_clr(); rsp_idx = 0; rsp_dly = 2; rsp_hold = 3;
    do_start(8'd2);
    idle(20);
    @(negedge clk);
    chk("lh_busy", busy, 1'b1);
    tick();
    num_inputs = 8'd0; start = 1'b1; tick(); start = 1'b0;
    wait_done("lh", 400);
    chk("lh_gw_rise", gw_rise, 8);
    chk("lh_gi_rise", gi_rise, 2);
    chk("lh_wloads", wl_cnt, 8);
    chk("lh_iloads", il_cnt, 2);
    chk("lh_data", dat_err, 0);
    chk("lh_err", err_at_done, 1'b0);
    idle(3);
    chk("lh_done_once", done_cnt, 1);
    chk("lh_viol", viol, 0);

    // num_inputs = 0
    idle(8); mon_clr(); rsp_dly = 4; rsp_hold = 1;
    do_start(8'd0);
    @(negedge clk);
    chk("z_done", done, 1'b1);
    chk("z_err", err, 1'b1);
    chk("z_req", {get_weights, get_inputs, get_out}, 3'b000);
    tick();
    @(negedge clk);
    chk("z_busy", busy, 1'b0);
    chk("z_done_clr", done, 1'b0);
    chk("z_err_sticky", err, 1'b1);
    chk("z_gw_rise", gw_rise, 0);

    // next start clears err; occupancy_err during REQ_I
    idle(3); mon_clr(); rsp_idx = 0;
    do_start(8'd2);
    @(negedge clk);
    chk("clr_err", err, 1'b0);
    for (int i = 0; i < 300 && !get_inputs; i++) tick();
    chk("oe_reach", get_inputs, 1'b1);
    occupancy_err = 1'b1;
    tick();
    occupancy_err = 1'b0;
    @(negedge clk);
    chk("oe_err", err, 1'b1);
    chk("oe_done", done, 1'b1);
    chk("oe_req", {get_weights, get_inputs, get_out}, 3'b000);
    tick();
    @(negedge clk);
    chk("oe_idle", busy, 1'b0);
    chk("oe_iloads", il_cnt, 0);

    // timeout in REQ_W
    idle(10); mon_clr(); rsp_en = 1'b0;
    do_start(8'd1);
    s = cyc;
    wait_done("to", 1200);
    chk("to_latency", done_cyc - s, TO + 1);
    chk("to_err", err_at_done, 1'b1);
    chk("to_gw_hi", gw_hi, TO + 1);
    chk("to_gw_rise", gw_rise, 1);
    rsp_en = 1'b1;

    // reset during LOAD_I
    idle(5); mon_clr(); rsp_idx = 0;
    do_start(8'd3);
    for (int i = 0; i < 300 && !(wl_cnt == NW && array_data != 64'd0); i++) tick();
    chk("rs_reach", 64'(array_data != 64'd0), 64'd1);
    n_rst = 1'b1;
    tick();
    n_rst = 1'b0;
    @(negedge clk);
    chk("rs_ctrl", {busy, done, err, get_weights, get_inputs, get_out, weight_load, input_load}, 8'h00);
    chk("rs_data", array_data, 64'd0);
    idle(4);
    chk("rs_no_done", done_cnt, 0);
    chk("rs_stay_idle", {busy, get_weights, get_inputs}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
